// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the IF/MEM bus arbiter
//
// Holds the arbiter state encoding, the control-level constants shared with
// the pipeline (reset level, stall level, zero word, stall-vector indices),
// and the registered bus request bundle with a small constructor helper.
package bus_arbiter_pkg;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic        NO_STOP    = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [3:0]  SEL_WORD   = 4'b1111;

    // Positions inside the 6-bit pipeline stall vector.
    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DBUS      = 3'd1,
        ST_IBUS      = 3'd2,
        ST_DDONE     = 3'd3,
        ST_IDONE     = 3'd4,
        ST_FLUSHWAIT = 3'd5
    } arb_state_t;

    // Everything the arbiter drives onto the shared bus, kept as one register.
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // A freshly opened bus cycle: strobes raised with the given attributes.
    function automatic bus_req_t bus_open(
        input logic        we,
        input logic [3:0]  sel,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        bus_req_t r;
        r.cyc   = 1'b1;
        r.stb   = 1'b1;
        r.we    = we;
        r.sel   = sel;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    // States in which a bus cycle is outstanding and bus_ack is meaningful.
    function automatic logic is_bus_state(input arb_state_t s);
        return (s == ST_DBUS) || (s == ST_IBUS) || (s == ST_FLUSHWAIT);
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - single shared memory bus arbiter between fetch (IF) and data (MEM)
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   stall[5:0], flush        pipeline control (stall[1] = if, stall[4] = mem)
//   if_ce, if_addr           fetch request        -> if_rdata, stallreq_if
//   mem_ce/we/sel/addr/wdata data request         -> mem_rdata, stallreq_mem
//   bus_cyc/stb/we/sel/addr/wdata  registered master side of the shared bus
//   bus_rdata, bus_ack       slave read data and completion
//
// One transaction at a time; the data side wins when both ask in the same
// cycle. A flush never aborts a bus cycle already issued: the arbiter parks
// in FLUSHWAIT until the slave acks, then drops the returned data.
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,

    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        stallreq_if,

    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        stallreq_mem,

    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    arb_state_t state;
    arb_state_t state_nxt;

    bus_req_t   bus_q;
    bus_req_t   bus_d;

    logic start_d;
    logic start_i;
    logic bus_done;
    logic cap_d;
    logic cap_i;

    // Only the IF and MEM stall bits matter to the arbiter.
    logic stall_unused;
    assign stall_unused = ^{stall[5], stall[3:2], stall[0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush is evaluated before stall or new requests.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!flush) begin
                    if (mem_ce) begin
                        state_nxt = ST_DBUS;
                    end else if (if_ce) begin
                        state_nxt = ST_IBUS;
                    end
                end
            end
            ST_DBUS: begin
                if (flush) begin
                    state_nxt = bus_ack ? ST_IDLE : ST_FLUSHWAIT;
                end else if (bus_ack) begin
                    state_nxt = ST_DDONE;
                end
            end
            ST_IBUS: begin
                if (flush) begin
                    state_nxt = bus_ack ? ST_IDLE : ST_FLUSHWAIT;
                end else if (bus_ack) begin
                    state_nxt = ST_IDONE;
                end
            end
            ST_DDONE: begin
                if (flush || (stall[STALL_MEM] == NO_STOP)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDONE: begin
                if (flush || (stall[STALL_IF] == NO_STOP)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSHWAIT: begin
                if (bus_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: stall requests, bus register next value, capture strobes
    // ------------------------------------------------------------------
    always_comb begin
        // A requester is released only once its result is parked in a DONE
        // state; FLUSHWAIT keeps any new request waiting behind the old cycle.
        stallreq_mem = mem_ce && (state != ST_DDONE);
        stallreq_if  = if_ce  && (state != ST_IDONE);

        start_d  = (state == ST_IDLE) && !flush && mem_ce;
        start_i  = (state == ST_IDLE) && !flush && !mem_ce && if_ce;
        bus_done = is_bus_state(state) && bus_ack;

        // Data returned during a flush belongs to a squashed instruction.
        cap_d = (state == ST_DBUS) && bus_ack && !flush;
        cap_i = (state == ST_IBUS) && bus_ack && !flush;

        bus_d = bus_q;
        if (start_d) begin
            bus_d = bus_open(mem_we, mem_sel, mem_addr, mem_wdata);
        end else if (start_i) begin
            bus_d = bus_open(1'b0, SEL_WORD, if_addr, ZERO_WORD);
        end else if (bus_done) begin
            // Address/sel/wdata are left as they were; only the strobes close.
            bus_d.cyc = 1'b0;
            bus_d.stb = 1'b0;
            bus_d.we  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered bus outputs and read-data holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            bus_q     <= '0;
            if_rdata  <= ZERO_WORD;
            mem_rdata <= ZERO_WORD;
        end else begin
            bus_q <= bus_d;
            if (cap_d) begin
                mem_rdata <= bus_rdata;
            end
            if (cap_i) begin
                if_rdata <= bus_rdata;
            end
        end
    end

    assign bus_cyc   = bus_q.cyc;
    assign bus_stb   = bus_q.stb;
    assign bus_we    = bus_q.we;
    assign bus_sel   = bus_q.sel;
    assign bus_addr  = bus_q.addr;
    assign bus_wdata = bus_q.wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stallreq_if;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_mem;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .if_ce        (if_ce),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .stallreq_if  (stallreq_if),
        .mem_ce       (mem_ce),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stallreq_mem (stallreq_mem),
        .bus_cyc      (bus_cyc),
        .bus_stb      (bus_stb),
        .bus_we       (bus_we),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural memory / slave ----------------
    logic [31:0] slave_mem [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    bit          auto_slave = 0;
    bit          s_busy = 0;
    int          s_wait = 0;
    int          s_lat  = 0;
    logic [72:0] s_snap;
    int          s_acks = 0;
    int          s_unstable = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic slave_step();
        bus_ack = 1'b0;
        if (bus_cyc && bus_stb) begin
            if (s_busy) begin
                if ({bus_we, bus_sel, bus_addr, bus_wdata} !== s_snap) s_unstable++;
            end else begin
                s_busy = 1;
                s_snap = {bus_we, bus_sel, bus_addr, bus_wdata};
                s_wait = 0;
                s_lat  = $urandom_range(0, 3);
            end
            if (s_wait == s_lat) begin
                bus_ack = 1'b1;
                s_acks++;
                if (bus_we) begin
                    slave_mem[bus_addr] = merge(slave_rd(bus_addr), bus_wdata, bus_sel);
                    bus_rdata = $urandom;
                end else begin
                    bus_rdata = slave_rd(bus_addr);
                end
                s_busy = 0;
            end else begin
                s_wait++;
            end
        end else begin
            s_busy = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (auto_slave) slave_step();
    endtask

    task automatic clear_inputs();
        stall = 6'b0; flush = 0; if_ce = 0; if_addr = 0;
        mem_ce = 0; mem_we = 0; mem_sel = 0; mem_addr = 0; mem_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        is_data;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_delay;
        logic [31:0] ack_data;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];
    vec_t r;
    int   n;
    bit   done;

    // random-phase state
    int          kind;
    bit          d_pend, i_pend, d_is_load;
    logic [31:0] d_addr, i_addr, d_wdata, held;
    logic [3:0]  d_sel;
    int          exp_acks;
    int          budget;
    int          hold;

    initial begin
        vt[0] = '{0, 1, 4'h3, 32'h0000_0100, 32'h0000_CAFE, 2, 32'h2401_0005, 0, 4'hF, 32'h0};
        vt[1] = '{1, 1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1, 4'hF, 32'hDEAD_BEEF};
        vt[2] = '{1, 0, 4'h3, 32'h8000_0020, 32'h1111_1111, 1, 32'h0000_ABCD, 0, 4'h3, 32'h1111_1111};
        vt[3] = '{0, 0, 4'h0, 32'hBFC0_0000, 32'h0,         0, 32'h3C08_BFC0, 0, 4'hF, 32'h0};
        vt[4] = '{1, 1, 4'h8, 32'h0000_0004, 32'hAA00_0000, 3, 32'h0000_0055, 1, 4'h8, 32'hAA00_0000};
        vt[5] = '{1, 0, 4'hF, 32'hFFFF_FFFC, 32'h0,         0, 32'hFFFF_FFFF, 0, 4'hF, 32'h0};

        clear_inputs();
        rst = 0;
        tick(); tick();
        check("rst_cyc",   {31'b0, bus_cyc}, 0);
        check("rst_stb",   {31'b0, bus_stb}, 0);
        check("rst_we",    {31'b0, bus_we}, 0);
        check("rst_sel",   {28'b0, bus_sel}, 0);
        check("rst_addr",  bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_if_rdata",  if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        rst = 1;
        tick();

        // ---- table: single transactions with scripted ack delay ----
        for (int v = 0; v < NV; v++) begin
            r = vt[v];
            mem_we = r.we; mem_sel = r.sel; mem_wdata = r.wdata;
            if (r.is_data) begin
                mem_ce = 1; mem_addr = r.addr; if_ce = 0;
            end else begin
                mem_ce = 0; if_ce = 1; if_addr = r.addr;
            end
            n = 0; done = 0;
            while (!done && n < 20) begin
                tick(); n++;
                done = r.is_data ? !stallreq_mem : !stallreq_if;
                if (!done) begin
                    if (n == 1) begin
                        check($sformatf("v%0d_cyc", v),   {30'b0, bus_cyc, bus_stb}, 32'h3);
                        check($sformatf("v%0d_addr", v),  bus_addr, r.addr);
                        check($sformatf("v%0d_sel", v),   {28'b0, bus_sel}, {28'b0, r.exp_sel});
                        check($sformatf("v%0d_we", v),    {31'b0, bus_we}, {31'b0, r.exp_we});
                        check($sformatf("v%0d_wdata", v), bus_wdata, r.exp_wdata);
                    end
                    bus_ack   = (n == 1 + r.ack_delay);
                    bus_rdata = bus_ack ? r.ack_data : 32'h0;
                end else begin
                    bus_ack = 0;
                end
            end
            check($sformatf("v%0d_latency", v), n, 2 + r.ack_delay);
            check($sformatf("v%0d_rdata", v), r.is_data ? mem_rdata : if_rdata, r.ack_data);
            check($sformatf("v%0d_closed", v), {29'b0, bus_cyc, bus_stb, bus_we}, 0);
            mem_ce = 0; if_ce = 0; bus_ack = 0;
            tick();
        end

        // ---- both requesters in IDLE: data first, then fetch ----
        mem_ce = 1; mem_we = 1; mem_sel = 4'hF; mem_addr = 32'h8000_0010; mem_wdata = 32'hDEAD_BEEF;
        if_ce = 1; if_addr = 32'h0000_0200;
        tick();
        check("both_d_addr", bus_addr, 32'h8000_0010);
        check("both_d_we", {31'b0, bus_we}, 1);
        check("both_if_stalled", {31'b0, stallreq_if}, 1);
        bus_ack = 1; bus_rdata = 32'h0;
        tick();
        bus_ack = 0;
        check("both_d_done", {30'b0, stallreq_mem, stallreq_if}, 32'h1);
        mem_ce = 0;
        tick();
        check("both_gap_idle", {31'b0, bus_cyc}, 0);
        tick();
        check("both_i_cyc", {31'b0, bus_cyc}, 1);
        check("both_i_addr", bus_addr, 32'h0000_0200);
        check("both_i_we_sel", {27'b0, bus_we, bus_sel}, 32'h0F);
        bus_ack = 1; bus_rdata = 32'h1122_3344;
        tick();
        bus_ack = 0;
        check("both_i_done", {31'b0, stallreq_if}, 0);
        check("both_i_rdata", if_rdata, 32'h1122_3344);
        if_ce = 0;
        tick();

        // ---- flush during IBUS: bus held, ack data dropped, waiting request ----
        if_ce = 1; if_addr = 32'h0000_0300;
        tick();
        check("fl_ibus_cyc", {31'b0, bus_cyc}, 1);
        flush = 1;
        tick();
        flush = 0;
        check("fl_wait_if_req", {31'b0, stallreq_if}, 1);
        if_ce = 0;
        mem_ce = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h0000_0040;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("fl_hold_cyc%0d", k), {30'b0, bus_cyc, bus_stb}, 32'h3);
            check($sformatf("fl_hold_addr%0d", k), bus_addr, 32'h0000_0300);
            check($sformatf("fl_wait_mem_req%0d", k), {31'b0, stallreq_mem}, 1);
        end
        bus_ack = 1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 0;
        check("fl_closed", {31'b0, bus_cyc}, 0);
        check("fl_if_rdata_kept", if_rdata, 32'h1122_3344);
        check("fl_mem_rdata_kept", mem_rdata, 32'h0000_0000);
        tick();
        check("fl_next_addr", bus_addr, 32'h0000_0040);
        check("fl_next_cyc", {31'b0, bus_cyc}, 1);
        bus_ack = 1; bus_rdata = 32'h0000_4040;
        tick();
        bus_ack = 0;
        check("fl_next_rdata", mem_rdata, 32'h0000_4040);
        mem_ce = 0;
        tick();

        // ---- flush and ack in the same DBUS cycle ----
        mem_ce = 1; mem_addr = 32'h0000_0050;
        tick();
        flush = 1; bus_ack = 1; bus_rdata = 32'h9999_9999; mem_ce = 0;
        tick();
        flush = 0; bus_ack = 0;
        check("flack_closed", {31'b0, bus_cyc}, 0);
        check("flack_rdata_kept", mem_rdata, 32'h0000_4040);
        if_ce = 1; if_addr = 32'h0000_0060;
        tick();
        check("flack_idle_restart", {31'b0, bus_cyc}, 1);
        bus_ack = 1; bus_rdata = 32'h0000_0606;
        tick();
        bus_ack = 0; if_ce = 0;
        tick();

        // ---- DDONE held by stall[4] ----
        mem_ce = 1; mem_addr = 32'h0000_0070;
        tick();
        bus_ack = 1; bus_rdata = 32'h600D_F00D;
        tick();
        bus_ack = 0;
        stall[4] = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ddone_rdata%0d", k), mem_rdata, 32'h600D_F00D);
            check($sformatf("ddone_nobus%0d", k), {30'b0, bus_cyc, stallreq_mem}, 0);
        end
        stall[4] = 0; mem_ce = 0;
        tick();
        check("ddone_release", {31'b0, bus_cyc}, 0);

        // ---- flush in IDLE beats pending requests ----
        mem_ce = 1; if_ce = 1; flush = 1;
        tick();
        check("idle_flush_nobus", {31'b0, bus_cyc}, 0);
        mem_ce = 0; if_ce = 0; flush = 0;
        tick();

        // ---- reset in the middle of DBUS ----
        mem_ce = 1; mem_we = 1; mem_addr = 32'h0000_0070; mem_wdata = 32'h77;
        tick();
        check("rstmid_cyc_before", {31'b0, bus_cyc}, 1);
        rst = 0; flush = 1; bus_ack = 1; bus_rdata = 32'hFFFF_0000;
        tick();
        check("rstmid_strobes", {29'b0, bus_cyc, bus_stb, bus_we}, 0);
        check("rstmid_addr", bus_addr, 0);
        check("rstmid_rdata", mem_rdata | if_rdata, 0);
        rst = 1; clear_inputs();
        tick();
        check("rstmid_idle", {31'b0, bus_cyc}, 0);

        // ---- randomized traffic against a memory model ----
        auto_slave = 1;
        exp_acks = s_acks;
        for (int t = 0; t < 200; t++) begin
            kind   = $urandom_range(0, 4);
            d_pend = (kind != 2);
            i_pend = (kind >= 2);
            d_is_load = (kind == 0) || (kind == 3);
            d_addr  = 32'($urandom_range(0, 15)) << 2;
            i_addr  = 32'($urandom_range(0, 15)) << 2;
            d_sel   = d_is_load ? 4'hF : 4'($urandom_range(1, 15));
            d_wdata = $urandom;
            mem_ce = d_pend; mem_we = !d_is_load; mem_sel = d_sel;
            mem_addr = d_addr; mem_wdata = d_wdata;
            if_ce = i_pend; if_addr = i_addr;
            budget = 0;
            while ((d_pend || i_pend) && budget < 60) begin
                tick(); budget++;
                if (d_pend && !stallreq_mem) begin
                    if (d_is_load) check($sformatf("rnd%0d_load", t), mem_rdata, ref_rd(d_addr));
                    else ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_sel);
                    exp_acks++;
                    held = mem_rdata;
                    hold = $urandom_range(0, 2);
                    if (hold > 0) begin
                        stall[4] = 1;
                        for (int h = 0; h < hold; h++) begin
                            tick();
                            check($sformatf("rnd%0d_dhold", t), {stallreq_mem, bus_cyc, mem_rdata}, {2'b00, held});
                        end
                        stall[4] = 0;
                    end
                    mem_ce = 0; d_pend = 0;
                end else if (i_pend && !stallreq_if) begin
                    check($sformatf("rnd%0d_fetch", t), if_rdata, ref_rd(i_addr));
                    exp_acks++;
                    held = if_rdata;
                    hold = $urandom_range(0, 2);
                    if (hold > 0) begin
                        stall[1] = 1;
                        for (int h = 0; h < hold; h++) begin
                            tick();
                            check($sformatf("rnd%0d_ihold", t), {stallreq_if, bus_cyc, if_rdata}, {2'b00, held});
                        end
                        stall[1] = 0;
                    end
                    if_ce = 0; i_pend = 0;
                end
            end
            if (d_pend || i_pend) begin
                check($sformatf("rnd%0d_timeout", t), {30'b0, d_pend, i_pend}, 0);
                mem_ce = 0; if_ce = 0;
                rst = 0; tick(); tick(); rst = 1;
            end
        end
        tick(); tick();
        auto_slave = 0;
        check("rnd_bus_cycle_count", s_acks, exp_acks);
        check("rnd_bus_stable", s_unstable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
